seg_blink_scan: RTL and testbench

- Consumer end of the slow blink clock produced by the team's blink clock divider.
- Resynchronises that square wave into the system clock domain and detects its edges.
- Multiplexes four hex digits onto a common-anode seven-segment display.
- Blanks selected digits during the off-phase of the blink, and runs a counted whole-display flash sequence with a busy/done handshake for the calculator's result and error indication.

---
 rtl/seg_blink_scan.sv | 149 ++++++++++++++
 tb/tb_seg_blink_scan.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_blink_scan.sv
// seg_blink_scan: resynchronises the slow blink square wave, scans four hex
// digits onto a common-anode seven-segment display, blanks selected digits in
// the blink off-phase and runs a counted whole-display flash with busy/done.
module seg_blink_scan #(
  parameter int unsigned SCAN_DIV  = 17, // refresh counter width; digit select = top 2 bits
  parameter int unsigned FLASH_CNT = 3   // blink periods per flash sequence, 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_blink,
  input  logic [15:0] digits,
  input  logic [3:0]  blink_mask,
  input  logic        flash_start,
  output logic        busy,
  output logic        flash_done,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ALIGN = 2'd1;
  localparam logic [1:0] FLASH = 2'd2;

  localparam logic [3:0] FLASH_LAST = 4'(FLASH_CNT - 1);

  logic                s1, s2, s3;
  logic                rise, off;
  logic [SCAN_DIV-1:0] scan_cnt;
  logic [1:0]          sel;
  logic [3:0]          nibble;
  logic                blank;
  logic [6:0]          seg_next;
  logic [3:0]          an_next;
  logic [1:0]          state;
  logic [3:0]          fcnt;

  // Hex digit to active-low segment pattern, g..a.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous blink wave plus a delayed copy for edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_blink;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign off  = ~s2;

  // Free-running refresh counter; its top two bits select the digit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + {{(SCAN_DIV-1){1'b0}}, 1'b1};
    end
  end

  assign sel = scan_cnt[SCAN_DIV-1 -: 2];

  // Next display value: live digit decode, blanked in the off-phase for masked digits or during a flash.
  always_comb begin
    nibble   = digits[{sel, 2'b00} +: 4];
    blank    = (blink_mask[sel] & off) | ((state == FLASH) & off);
    seg_next = '1;
    an_next  = '1;
    if (!blank) begin
      seg_next = hex7(nibble);
      an_next  = ~(4'b0001 << sel);
    end
  end

  // Registered display outputs so anode and segment change together on one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= '1;
      an  <= '1;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

  // Flash sequencer: align to a blink rise, then count FLASH_CNT full periods rise to rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      fcnt       <= '0;
      flash_done <= 1'b0;
    end else begin
      flash_done <= 1'b0;
      case (state)
        IDLE: begin
          // A rise coinciding with the request is not used for alignment.
          if (flash_start) begin
            state <= ALIGN;
          end
        end
        ALIGN: begin
          if (rise) begin
            state <= FLASH;
            fcnt  <= '0;
          end
        end
        FLASH: begin
          if (rise) begin
            if (fcnt == FLASH_LAST) begin
              state      <= IDLE;
              flash_done <= 1'b1;
            end else begin
              fcnt <= fcnt + 4'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_seg_blink_scan.sv
// Self-checking bench for seg_blink_scan: two instances (FLASH_CNT 3 and 1)
// share inputs; a cycle-level reference model plus directed sequences.
module tb_seg_blink_scan;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_blink = 1'b1;
  logic [15:0] digits = 16'h1208;
  logic [3:0] blink_mask = 4'b0000;
  logic       flash_start = 1'b0;

  logic       busy_0, flash_done_0, busy_1, flash_done_1;
  logic [6:0] seg_0, seg_1;
  logic [3:0] an_0, an_1;

  seg_blink_scan #(.SCAN_DIV(SD), .FLASH_CNT(3)) u0 (
    .clk(clk), .rst_n(rst_n), .clk_blink(clk_blink), .digits(digits),
    .blink_mask(blink_mask), .flash_start(flash_start),
    .busy(busy_0), .flash_done(flash_done_0), .seg(seg_0), .an(an_0)
  );

  seg_blink_scan #(.SCAN_DIV(SD), .FLASH_CNT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clk_blink(clk_blink), .digits(digits),
    .blink_mask(blink_mask), .flash_start(flash_start),
    .busy(busy_1), .flash_done(flash_done_1), .seg(seg_1), .an(an_1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ecount = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) ecount <= ecount + 1;

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int   fc [2] = '{3, 1};
  int   m_cyc = 0;
  logic m_hist [3] = '{1'b0, 1'b0, 1'b0};
  int   m_mode [2] = '{0, 0};   // 0 idle, 1 waiting for first rise, 2 flashing
  int   m_nr [2] = '{0, 0};     // rises seen while flashing
  logic [3:0] e_an [2] = '{4'hF, 4'hF};
  logic [6:0] e_seg [2] = '{7'h7F, 7'h7F};
  logic e_busy [2] = '{1'b0, 1'b0};
  logic e_done [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin : ref_model
    int sel;
    logic off, rise, blank;
    sel  = (m_cyc / (1 << (SD - 2))) % 4;
    off  = !m_hist[1];
    rise = m_hist[1] && !m_hist[2];
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_mode[k] = 0; m_nr[k] = 0; e_done[k] = 1'b0;
        e_an[k] = 4'hF; e_seg[k] = 7'h7F;
      end else begin
        blank = (blink_mask[sel] && off) || (m_mode[k] == 2 && off);
        if (blank) begin
          e_an[k] = 4'hF; e_seg[k] = 7'h7F;
        end else begin
          e_an[k] = 4'hF ^ (4'b0001 << sel);
          e_seg[k] = seg_tab[digits[sel*4 +: 4]];
        end
        e_done[k] = 1'b0;
        if (m_mode[k] == 0) begin
          if (flash_start) m_mode[k] = 1;
        end else if (m_mode[k] == 1) begin
          if (rise) begin m_mode[k] = 2; m_nr[k] = 0; end
        end else if (rise) begin
          m_nr[k]++;
          if (m_nr[k] == fc[k]) begin m_mode[k] = 0; e_done[k] = 1'b1; end
        end
      end
      e_busy[k] = (m_mode[k] != 0);
    end
    if (!rst_n) begin
      m_cyc = 0; m_hist[0] = 1'b0; m_hist[1] = 1'b0; m_hist[2] = 1'b0;
    end else begin
      m_cyc = (m_cyc + 1) % (1 << SD);
      m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = clk_blink;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_an0", an_0, e_an[0]);
      chk("model_seg0", seg_0, e_seg[0]);
      chk("model_busy0", busy_0, e_busy[0]);
      chk("model_done0", flash_done_0, e_done[0]);
      chk("model_an1", an_1, e_an[1]);
      chk("model_seg1", seg_1, e_seg[1]);
      chk("model_busy1", busy_1, e_busy[1]);
      chk("model_done1", flash_done_1, e_done[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    logic [3:0] val;
    logic [6:0] exp;
  } dec_vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } scan_vec_t;

  dec_vec_t  dv [16];
  scan_vec_t sv [4];

  int ph = 0;
  int nrise = 0;
  int rise_edge [8];

  task automatic tick();
    @(negedge clk);
  endtask

  // Square wave of 40 cycles; records the edge count at each driven rise.
  task automatic drive_sq();
    logic nb;
    ph++;
    nb = ((ph % 40) >= 20);
    if (nb && !clk_blink) begin
      nrise++;
      if (nrise < 8) rise_edge[nrise] = ecount;
    end
    clk_blink = nb;
  endtask

  initial begin
    int cnt, fin, done_edge, busy_drop, pulsed, r2;
    logic busy_at;

    dv[0]  = '{4'h0, 7'b1000000}; dv[1]  = '{4'h1, 7'b1111001};
    dv[2]  = '{4'h2, 7'b0100100}; dv[3]  = '{4'h3, 7'b0110000};
    dv[4]  = '{4'h4, 7'b0011001}; dv[5]  = '{4'h5, 7'b0010010};
    dv[6]  = '{4'h6, 7'b0000010}; dv[7]  = '{4'h7, 7'b1111000};
    dv[8]  = '{4'h8, 7'b0000000}; dv[9]  = '{4'h9, 7'b0010000};
    dv[10] = '{4'hA, 7'b0001000}; dv[11] = '{4'hB, 7'b0000011};
    dv[12] = '{4'hC, 7'b1000110}; dv[13] = '{4'hD, 7'b0100001};
    dv[14] = '{4'hE, 7'b0000110}; dv[15] = '{4'hF, 7'b0001110};
    // digits 16'h1208: digit0=8, digit1=0, digit2=2, digit3=1
    sv[0] = '{4'b1110, 7'b0000000};
    sv[1] = '{4'b1101, 7'b1000000};
    sv[2] = '{4'b1011, 7'b0100100};
    sv[3] = '{4'b0111, 7'b1111001};

    // Reset values
    tick();
    chk_en = 1'b1;
    tick(); tick();
    chk("rst_seg", seg_0, 7'h7F);
    chk("rst_an", an_0, 4'hF);
    chk("rst_busy", busy_0, 1'b0);
    chk("rst_done", flash_done_0, 1'b0);
    rst_n = 1'b1;

    // Scan order after reset: 4 cycles per digit
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("scan_an", an_0, sv[k/4].an);
      chk("scan_seg", seg_0, sv[k/4].seg);
    end

    // Decode table, all four digits equal
    for (int i = 0; i < 16; i++) begin
      digits = {4{dv[i].val}};
      tick(); tick();
      chk("decode", seg_0, dv[i].exp);
    end

    // Blink mask on digit0 in the off phase
    digits = 16'h1208;
    blink_mask = 4'b0001;
    clk_blink = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    cnt = 0; busy_drop = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (an_0 == 4'b1110) cnt++;
      if (an_0 == 4'b1101) busy_drop++;
    end
    chk("mask_digit0_hidden", cnt, 0);
    chk("mask_digit1_shown", busy_drop, 4);
    clk_blink = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (an_0 == 4'b1110) cnt++;
    end
    chk("mask_digit0_back", cnt, 4);
    blink_mask = 4'b0000;

    // Flash sequence, FLASH_CNT=3, blink period 40 cycles, retrigger mid-flash
    ph = 30; nrise = 0;
    tick(); flash_start = 1'b1;
    tick(); flash_start = 1'b0;
    chk("busy_after_start", busy_0, 1'b1);
    fin = 0; busy_drop = 0; pulsed = 0; done_edge = 0; busy_at = 1'b1;
    for (int i = 0; i < 400 && fin == 0; i++) begin
      tick();
      flash_start = 1'b0;
      if (flash_done_0) begin
        fin = 1; done_edge = ecount; busy_at = busy_0;
      end else begin
        if (!busy_0) busy_drop++;
        if (nrise == 2 && pulsed == 0 && ecount == rise_edge[2] + 10) begin
          flash_start = 1'b1; pulsed = 1;
        end
        drive_sq();
      end
    end
    chk("flash_done_seen", fin, 1);
    chk("flash_done_at_rise4", done_edge, rise_edge[4] + 3);
    chk("busy_low_with_done", busy_at, 1'b0);
    chk("busy_held_during_flash", busy_drop, 0);
    drive_sq();
    tick();
    chk("done_one_cycle", flash_done_0, 1'b0);
    flash_start = 1'b1;
    drive_sq();
    tick();
    flash_start = 1'b0;
    chk("restart_after_done", busy_0, 1'b1);

    // Reset mid-flash after two synced rises
    nrise = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (nrise >= 2 && ecount >= rise_edge[2] + 5) break;
      drive_sq();
    end
    chk("busy_before_reset", busy_0, 1'b1);
    rst_n = 1'b0;
    drive_sq();
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", busy_0, 1'b0);
    chk("midrst_done", flash_done_0, 1'b0);
    chk("midrst_an", an_0, 4'hF);
    chk("midrst_seg", seg_0, 7'h7F);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      drive_sq();
      tick();
      if (flash_done_0 || busy_0) cnt++;
    end
    chk("idle_after_midrst", cnt, 0);

    // Single toggles with FLASH_CNT=1: align on first rise, done on second
    clk_blink = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    flash_start = 1'b1;
    tick();
    flash_start = 1'b0;
    chk("u1_busy_after_start", busy_1, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    clk_blink = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (flash_done_1) cnt++;
    end
    chk("u1_no_done_on_align", cnt, 0);
    chk("u1_busy_stuck_level", busy_1, 1'b1);
    clk_blink = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    clk_blink = 1'b1;
    r2 = ecount;
    done_edge = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (flash_done_1) begin done_edge = ecount; break; end
    end
    chk("u1_done_2cyc_sync", done_edge, r2 + 3);

    // Randomised traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_n = ($urandom_range(0, 299) != 0);
      digits = 16'($urandom);
      if ($urandom_range(0, 7) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(0, 5) == 0) clk_blink = ~clk_blink;
      flash_start = ($urandom_range(0, 9) == 0);
    end
    tick();
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
